// File: rtl/lock_key_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : lock_key_conditioner_if
// Description : Signal bundle between the raw key/switch inputs and the lock
//               FSM. The slave side is the conditioner; the master side
//               drives the raw inputs and consumes the clean digit stream.
// Revision    : 1.0 - initial release
// ============================================================================
interface lock_key_conditioner_if;
    logic       key_n;
    logic [3:0] sw;
    logic       clear;
    logic       digit_valid;
    logic [3:0] digit;
    logic       digit_bad;
    logic [2:0] press_count;
    logic       seq_done;
    logic       timeout;

    modport master (
        output key_n, sw, clear,
        input  digit_valid, digit, digit_bad, press_count, seq_done, timeout
    );

    modport slave (
        input  key_n, sw, clear,
        output digit_valid, digit, digit_bad, press_count, seq_done, timeout
    );
endinterface
`default_nettype wire

// File: rtl/lock_key_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : lock_key_conditioner
// Description : Synchronises and debounces the lock push-button and digit
//               switches, emitting one digit_valid strobe per press with the
//               switch value captured at that moment, and counts entered
//               digits (saturating at 6).
//               Optional macro LOCK_ENTRY_TIMEOUT_EN abandons a partial entry
//               after TIMEOUT_CYCLES idle cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module lock_key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TIMEOUT_CYCLES  = 500000000
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    lock_key_conditioner_if.slave bus
);

    localparam int               c_CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]       c_PC_MAX  = 3'd6;

    // Misconfiguration must stop elaboration rather than build a broken counter.
    if (DEBOUNCE_CYCLES < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("lock_key_conditioner: DEBOUNCE_CYCLES and TIMEOUT_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_HELD         = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } state_t;

    logic               r_key_meta;
    logic               r_key_s;
    logic [3:0]         r_sw_meta;
    logic [3:0]         r_sw_s;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_accept;
    logic               w_to_fire;
    logic [2:0]         w_pc_nxt;
    logic               r_digit_valid;
    logic [3:0]         r_digit;
    logic               r_digit_bad;
    logic [2:0]         r_press_count;
    logic               r_seq_done;

    // Two-flop synchronisers; key idles released (1), switches idle at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_meta <= 1'b1;
            r_key_s    <= 1'b1;
            r_sw_meta  <= 4'd0;
            r_sw_s     <= 4'd0;
        end else begin
            r_key_meta <= bus.key_n;
            r_key_s    <= r_key_meta;
            r_sw_meta  <= bus.sw;
            r_sw_s     <= r_sw_meta;
        end
    end

    // Debounce FSM state and shared wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; w_accept marks the single edge a press is accepted.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_key_s) begin
                    w_state_nxt = S_PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            S_PRESS_WAIT: begin
                if (r_key_s) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_CNT_MAX) begin
                    w_state_nxt = S_HELD;
                    w_accept    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_HELD: begin
                if (r_key_s) begin
                    w_state_nxt = S_RELEASE_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            S_RELEASE_WAIT: begin
                if (!r_key_s) begin
                    w_state_nxt = S_HELD;
                end else if (r_cnt == c_CNT_MAX) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

`ifdef LOCK_ENTRY_TIMEOUT_EN
    localparam int               c_TO_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_TO_W-1:0] c_TO_MAX = c_TO_W'(TIMEOUT_CYCLES - 1);

    logic [c_TO_W-1:0] r_to_cnt;
    logic              r_timeout;
    logic              w_to_run;

    // A partial entry (1..5 digits) is idle-timed; a strobe or clear wins.
    assign w_to_run  = (r_press_count >= 3'd1) && (r_press_count <= 3'd5);
    assign w_to_fire = w_to_run && (r_to_cnt == c_TO_MAX) && !w_accept && !bus.clear;

    // Idle counter restarts on every strobe, clear, expiry or when not running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_to_fire;
            if (w_accept || bus.clear || w_to_fire || !w_to_run) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    assign bus.timeout = r_timeout;
`else
    assign w_to_fire   = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    // Press counter: a strobe beats clear (count becomes 1), saturates at 6.
    always_comb begin
        w_pc_nxt = r_press_count;
        if (w_accept) begin
            if (bus.clear) begin
                w_pc_nxt = 3'd1;
            end else if (r_press_count != c_PC_MAX) begin
                w_pc_nxt = r_press_count + 3'd1;
            end
        end else if (bus.clear || w_to_fire) begin
            w_pc_nxt = 3'd0;
        end
    end

    // Registered outputs; digit and digit_bad only move with a strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit_valid <= 1'b0;
            r_digit       <= 4'd0;
            r_digit_bad   <= 1'b0;
            r_press_count <= 3'd0;
            r_seq_done    <= 1'b0;
        end else begin
            r_digit_valid <= w_accept;
            if (w_accept) begin
                r_digit     <= r_sw_s;
                r_digit_bad <= (r_sw_s > 4'd9);
            end
            r_press_count <= w_pc_nxt;
            r_seq_done    <= (w_pc_nxt == c_PC_MAX);
        end
    end

    assign bus.digit_valid = r_digit_valid;
    assign bus.digit       = r_digit;
    assign bus.digit_bad   = r_digit_bad;
    assign bus.press_count = r_press_count;
    assign bus.seq_done    = r_seq_done;

endmodule
`default_nettype wire

// File: tb/tb_lock_key_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_lock_key_conditioner
// Description : Directed self-checking bench for lock_key_conditioner with
//               DEBOUNCE_CYCLES=4 and TIMEOUT_CYCLES=50.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lock_key_conditioner;

    localparam int c_DEB = 4;
    localparam int c_TO  = 50;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_vec     = 0;
    int n_miss    = 0;
    int n_strobe  = 0;
    int n_timeout = 0;
    int base;

    lock_key_conditioner_if bus ();

    lock_key_conditioner #(
        .DEBOUNCE_CYCLES (c_DEB),
        .TIMEOUT_CYCLES  (c_TO)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 100 MHz bench clock.
    always #5 clk = ~clk;

    // Count strobes and timeout pulses on the inactive edge.
    always @(negedge clk) begin
        if (bus.digit_valid === 1'b1) n_strobe++;
        if (bus.timeout === 1'b1)     n_timeout++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        n_vec++;
        if (obs !== expd) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, expd);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold the key down until the strobe appears (bounded); returns just after it.
    task automatic press(input logic [3:0] v);
        bit seen;
        seen = 1'b0;
        bus.sw    = v;
        bus.key_n = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick(1);
            if (bus.digit_valid === 1'b1) seen = 1'b1;
        end
        check("strobe_seen", seen, 1);
    endtask

    task automatic release_key();
        bus.key_n = 1'b1;
        tick(10);
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        tick(1);
        bus.clear = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seq [6];
        seq = '{4'd7, 4'd2, 4'd2, 4'd2, 4'd9, 4'd7};

        bus.key_n = 1'b1;
        bus.sw    = 4'd0;
        bus.clear = 1'b0;
        tick(3);
        check("rst_valid", bus.digit_valid, 0);
        check("rst_digit", bus.digit, 0);
        check("rst_bad",   bus.digit_bad, 0);
        check("rst_count", bus.press_count, 0);
        check("rst_done",  bus.seq_done, 0);
        check("rst_tmo",   bus.timeout, 0);
        rst_n = 1'b1;
        tick(2);

        // Clean press: strobe exactly after edge 7.
        base      = n_strobe;
        bus.sw    = 4'd7;
        bus.key_n = 1'b0;
        tick(6);
        check("clean_early", bus.digit_valid, 0);
        tick(1);
        check("clean_valid", bus.digit_valid, 1);
        check("clean_digit", bus.digit, 7);
        check("clean_bad",   bus.digit_bad, 0);
        check("clean_count", bus.press_count, 1);
        check("clean_done",  bus.seq_done, 0);
        tick(1);
        check("clean_pulse_end", bus.digit_valid, 0);
        tick(12);
        check("clean_no_repeat", n_strobe - base, 1);
        release_key();

        // Bouncy press: 2 low / 1 high x5, then stays low.
        base   = n_strobe;
        bus.sw = 4'd3;
        for (int i = 0; i < 5; i++) begin
            bus.key_n = 1'b0;
            tick(2);
            bus.key_n = 1'b1;
            tick(1);
        end
        bus.key_n = 1'b0;
        tick(6);
        check("bounce_early", n_strobe - base, 0);
        tick(1);
        check("bounce_valid", bus.digit_valid, 1);
        check("bounce_digit", bus.digit, 3);
        check("bounce_count", bus.press_count, 2);
        tick(5);
        check("bounce_one", n_strobe - base, 1);
        release_key();

        // Release bounce while held must not re-strobe.
        pulse_clear();
        check("clear_count", bus.press_count, 0);
        press(4'd5);
        check("rb_digit", bus.digit, 5);
        check("rb_count", bus.press_count, 1);
        tick(3);
        base      = n_strobe;
        bus.key_n = 1'b1;
        tick(2);
        bus.key_n = 1'b0;
        tick(10);
        check("rb_no_strobe", n_strobe - base, 0);
        release_key();
        press(4'd8);
        check("rb2_digit", bus.digit, 8);
        check("rb2_count", bus.press_count, 2);
        release_key();

        // Six-digit sequence, then a saturating seventh press with a bad digit.
        pulse_clear();
        for (int i = 0; i < 6; i++) begin
            press(seq[i]);
            check("seq_digit", bus.digit, seq[i]);
            check("seq_count", bus.press_count, i + 1);
            check("seq_done",  bus.seq_done, (i == 5) ? 1 : 0);
            check("seq_bad",   bus.digit_bad, 0);
            release_key();
        end
        press(4'd12);
        check("sat_digit", bus.digit, 12);
        check("sat_bad",   bus.digit_bad, 1);
        check("sat_count", bus.press_count, 6);
        check("sat_done",  bus.seq_done, 1);
        release_key();

        // Clear coinciding with the accepting edge.
        bus.sw    = 4'd1;
        bus.key_n = 1'b0;
        tick(6);
        bus.clear = 1'b1;
        tick(1);
        bus.clear = 1'b0;
        check("clrstb_valid", bus.digit_valid, 1);
        check("clrstb_count", bus.press_count, 1);
        check("clrstb_done",  bus.seq_done, 0);
        check("clrstb_digit", bus.digit, 1);
        check("clrstb_bad",   bus.digit_bad, 0);
        release_key();

        // Reset during PRESS_WAIT; held key must debounce afresh after reset.
        bus.sw    = 4'd4;
        bus.key_n = 1'b0;
        tick(4);
        base  = n_strobe;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", bus.digit_valid, 0);
        check("midrst_digit", bus.digit, 0);
        check("midrst_bad",   bus.digit_bad, 0);
        check("midrst_count", bus.press_count, 0);
        check("midrst_done",  bus.seq_done, 0);
        tick(2);
        rst_n = 1'b1;
        tick(6);
        check("postrst_early", n_strobe - base, 0);
        tick(1);
        check("postrst_valid", bus.digit_valid, 1);
        check("postrst_digit", bus.digit, 4);
        check("postrst_count", bus.press_count, 1);
        release_key();

        // Idle after a single press.
        pulse_clear();
        press(4'd6);
        bus.key_n = 1'b1;
`ifdef LOCK_ENTRY_TIMEOUT_EN
        tick(49);
        check("tmo_early",       bus.timeout, 0);
        check("tmo_early_count", bus.press_count, 1);
        tick(1);
        check("tmo_pulse",       bus.timeout, 1);
        check("tmo_count",       bus.press_count, 0);
        tick(1);
        check("tmo_pulse_end",   bus.timeout, 0);
        check("tmo_count_hold",  bus.press_count, 0);
`else
        tick(60);
        check("notmo_level", bus.timeout, 0);
        check("notmo_count", bus.press_count, 1);
        check("notmo_pulses", n_timeout, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
